// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive controller slice.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop,
    StCheck
  } state_e;

  localparam int unsigned PRESCALE_8    = 8;
  localparam int unsigned PRESCALE_16   = 16;
  localparam int unsigned PRESCALE_32   = 32;
  localparam int unsigned SAMPLE_OFFSET = 2;
  localparam int unsigned DATA_BITS     = 8;

  function automatic logic prescale_legal(input int unsigned p);
    return (p == PRESCALE_8) || (p == PRESCALE_16) || (p == PRESCALE_32);
  endfunction

endpackage

// File: rtl/uart_rx_edge_cnt.sv
// Oversampling edge counter with wrap detect, plus the data bit index counter.
module uart_rx_edge_cnt
  import uart_rx_pkg::*;
#(
  parameter int unsigned PRESCALE_W = 6
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  cnt_en,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  bit_start,
  input  logic                  bit_inc,
  input  logic                  bit_clr,
  output logic [PRESCALE_W-1:0] edge_cnt,
  output logic                  edge_wrap,
  output logic [3:0]            bit_count,
  output logic                  bit_last
);

  logic [PRESCALE_W-1:0] edge_cnt_q;
  logic [3:0]            bit_count_q;

  assign edge_cnt  = edge_cnt_q;
  assign bit_count = bit_count_q;
  assign edge_wrap = cnt_en && (edge_cnt_q == prescale - PRESCALE_W'(1));
  assign bit_last  = (bit_count_q == 4'(DATA_BITS));

  always_ff @(posedge CLK) begin
    if (RST) begin
      edge_cnt_q  <= '0;
      bit_count_q <= '0;
    end else begin
      // Held at zero outside the frame so every START begins at edge 0.
      if (!cnt_en || edge_wrap) begin
        edge_cnt_q <= '0;
      end else begin
        edge_cnt_q <= edge_cnt_q + PRESCALE_W'(1);
      end

      if (bit_clr) begin
        bit_count_q <= '0;
      end else if (bit_start) begin
        bit_count_q <= 4'd1;
      end else if (bit_inc) begin
        bit_count_q <= bit_count_q + 4'd1;
      end
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive frame controller: start/data/parity/stop sequencing and checker strobes.
module uart_rx_ctrl
  import uart_rx_pkg::*;
#(
  parameter int unsigned PRESCALE_W = 6
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic                  PAR_EN,
  input  logic [PRESCALE_W-1:0] Prescale,
  input  logic                  Sampled_Bit,
  input  logic                  par_err,
  input  logic                  stp_err,
  input  logic                  strt_glitch,
  output logic                  data_samp_en,
  output logic                  desrializer_en,
  output logic [3:0]            bit_count,
  output logic                  strt_chk_en,
  output logic                  par_chk_en,
  output logic                  stp_chk_en,
  output logic                  DATA_VALID,
  output logic                  frame_err
);

  state_e                state_q;
  logic                  par_en_q;
  logic [PRESCALE_W-1:0] prescale_q;
  logic                  err_q;

  logic [PRESCALE_W-1:0] edge_cnt;
  logic [PRESCALE_W-1:0] pre_samp;
  logic                  at_pre_samp;
  logic                  edge_wrap;
  logic                  bit_last;
  logic                  cnt_en;
  logic                  bit_start;
  logic                  bit_inc;
  logic                  bit_clr;
  logic                  unused_sampled_bit;

  // Strobes are registered, so they are set one edge early to land on the sample point.
  assign pre_samp    = (prescale_q >> 1) + PRESCALE_W'(SAMPLE_OFFSET - 1);
  assign at_pre_samp = (edge_cnt == pre_samp);

  assign cnt_en       = (state_q == StStart) || (state_q == StData) ||
                        (state_q == StParity) || (state_q == StStop);
  assign bit_start    = (state_q == StStart) && edge_wrap;
  assign bit_inc      = (state_q == StData) && edge_wrap && !bit_last;
  assign bit_clr      = (state_q == StData) && edge_wrap && bit_last;
  assign data_samp_en = (state_q != StIdle);

  // The sampled bit goes straight to the deserializer; the controller only times it.
  assign unused_sampled_bit = Sampled_Bit;

  uart_rx_edge_cnt #(
    .PRESCALE_W (PRESCALE_W)
  ) u_edge_cnt (
    .CLK       (CLK),
    .RST       (RST),
    .cnt_en    (cnt_en),
    .prescale  (prescale_q),
    .bit_start (bit_start),
    .bit_inc   (bit_inc),
    .bit_clr   (bit_clr),
    .edge_cnt  (edge_cnt),
    .edge_wrap (edge_wrap),
    .bit_count (bit_count),
    .bit_last  (bit_last)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q        <= StIdle;
      par_en_q       <= 1'b0;
      prescale_q     <= '0;
      err_q          <= 1'b0;
      desrializer_en <= 1'b0;
      strt_chk_en    <= 1'b0;
      par_chk_en     <= 1'b0;
      stp_chk_en     <= 1'b0;
      DATA_VALID     <= 1'b0;
      frame_err      <= 1'b0;
    end else begin
      desrializer_en <= 1'b0;
      strt_chk_en    <= 1'b0;
      par_chk_en     <= 1'b0;
      stp_chk_en     <= 1'b0;
      DATA_VALID     <= 1'b0;
      frame_err      <= 1'b0;

      unique case (state_q)
        StIdle: begin
          if (!RX_IN) begin
            state_q    <= StStart;
            par_en_q   <= PAR_EN;
            prescale_q <= Prescale;
          end
        end
        StStart: begin
          if (at_pre_samp) strt_chk_en <= 1'b1;
          if (strt_chk_en && strt_glitch) begin
            state_q   <= StIdle;
            frame_err <= 1'b1;
          end else if (edge_wrap) begin
            state_q <= StData;
          end
        end
        StData: begin
          if (at_pre_samp) desrializer_en <= 1'b1;
          if (edge_wrap && bit_last) state_q <= par_en_q ? StParity : StStop;
        end
        StParity: begin
          if (at_pre_samp) par_chk_en <= 1'b1;
          if (par_chk_en && par_err) err_q <= 1'b1;
          if (edge_wrap) state_q <= StStop;
        end
        StStop: begin
          if (at_pre_samp) stp_chk_en <= 1'b1;
          // Leave right after the stop check so a following start bit is not missed.
          if (stp_chk_en) begin
            state_q    <= StCheck;
            DATA_VALID <= !(err_q || stp_err);
            frame_err  <= err_q || stp_err;
          end
        end
        StCheck: begin
          state_q <= StIdle;
          err_q   <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  a_prescale_legal: assert property (@(posedge CLK) disable iff (RST)
    (state_q == StIdle && !RX_IN) |-> prescale_legal(32'(Prescale)));

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl: frame table plus back-to-back and reset-abort sequences.
module tb_uart_rx_ctrl;

  localparam int unsigned PW = 6;

  logic          CLK = 1'b0;
  logic          RST;
  logic          RX_IN;
  logic          PAR_EN;
  logic [PW-1:0] Prescale;
  logic          Sampled_Bit;
  logic          par_err;
  logic          stp_err;
  logic          strt_glitch;
  logic          data_samp_en;
  logic          desrializer_en;
  logic [3:0]    bit_count;
  logic          strt_chk_en;
  logic          par_chk_en;
  logic          stp_chk_en;
  logic          DATA_VALID;
  logic          frame_err;

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  uart_rx_ctrl #(
    .PRESCALE_W (PW)
  ) dut (
    .CLK            (CLK),
    .RST            (RST),
    .RX_IN          (RX_IN),
    .PAR_EN         (PAR_EN),
    .Prescale       (Prescale),
    .Sampled_Bit    (Sampled_Bit),
    .par_err        (par_err),
    .stp_err        (stp_err),
    .strt_glitch    (strt_glitch),
    .data_samp_en   (data_samp_en),
    .desrializer_en (desrializer_en),
    .bit_count      (bit_count),
    .strt_chk_en    (strt_chk_en),
    .par_chk_en     (par_chk_en),
    .stp_chk_en     (stp_chk_en),
    .DATA_VALID     (DATA_VALID),
    .frame_err      (frame_err)
  );

  typedef struct {
    int         psc;
    logic       pen;
    logic [7:0] data;
    logic       glitch;
    logic       perr;
    logic       serr;
    logic       flip;
    int         exp_des;
    int         exp_par;
    int         exp_stp;
    int         exp_valid;
    int         exp_ferr;
    int         exp_lat;
  } vec_t;

  vec_t vecs[7];

  int         n_des, n_strt, n_par, n_stp, n_dv, n_fe, lat, order_err, both;
  logic [7:0] got_byte;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Serial line as seen from the bench, k cycles after the start bit is driven.
  function automatic logic line_bit(input vec_t v, input int k);
    int idx;
    if (v.glitch) return (k < 2) ? 1'b0 : 1'b1;
    idx = k / v.psc;
    if (idx == 0) return 1'b0;
    if (idx <= 8) return v.data[idx-1];
    if (v.pen && idx == 9) return ^v.data;
    return 1'b1;
  endfunction

  // Called on a negedge; returns on a negedge. skew = cycles between bench start and DUT START.
  task automatic run_frame(input vec_t v, input int skew, input int run_len);
    int s;
    s = v.psc / 2 + 2;
    n_des = 0; n_strt = 0; n_par = 0; n_stp = 0; n_dv = 0; n_fe = 0;
    lat = -1; order_err = 0; both = 0; got_byte = 8'h00;
    PAR_EN      = v.pen;
    Prescale    = PW'(v.psc);
    par_err     = v.perr;
    stp_err     = v.serr;
    strt_glitch = v.glitch;
    RX_IN       = line_bit(v, 0);
    Sampled_Bit = RX_IN;
    for (int k = 0; k < run_len; k++) begin
      @(posedge CLK);
      @(negedge CLK);
      if (desrializer_en) begin
        if (bit_count != 4'(n_des + 1) || k != v.psc * (n_des + 1) + s + skew) order_err++;
        if (bit_count >= 4'd1 && bit_count <= 4'd8) got_byte[3'(bit_count - 4'd1)] = Sampled_Bit;
        n_des++;
      end
      if (strt_chk_en) n_strt++;
      if (par_chk_en) n_par++;
      if (stp_chk_en) n_stp++;
      if (DATA_VALID) n_dv++;
      if (frame_err) n_fe++;
      if (DATA_VALID && frame_err) both++;
      if ((DATA_VALID || frame_err) && lat < 0) lat = k;
      if (v.flip && k == 3 * v.psc) begin
        PAR_EN   = 1'b1;
        Prescale = PW'(16);
      end
      if (k + 1 < run_len) begin
        RX_IN       = line_bit(v, k + 1);
        Sampled_Bit = RX_IN;
      end
    end
  endtask

  task automatic verify_frame(input vec_t v, input int skew, input string tag);
    check({tag, "_des_cnt"}, n_des, v.exp_des);
    check({tag, "_strt_cnt"}, n_strt, 1);
    check({tag, "_par_cnt"}, n_par, v.exp_par);
    check({tag, "_stp_cnt"}, n_stp, v.exp_stp);
    check({tag, "_valid_cnt"}, n_dv, v.exp_valid);
    check({tag, "_ferr_cnt"}, n_fe, v.exp_ferr);
    check({tag, "_latency"}, lat, v.exp_lat + skew);
    check({tag, "_bit_order"}, order_err, 0);
    check({tag, "_valid_and_ferr"}, both, 0);
    if (v.exp_des == 8) check({tag, "_byte"}, int'(got_byte), int'(v.data));
  endtask

  task automatic idle_cycles(input int n);
    RX_IN       = 1'b1;
    Sampled_Bit = 1'b1;
    repeat (n) @(negedge CLK);
  endtask

  initial begin
    vec_t va, vb;
    bit   found;
    int   late;

    //            psc pen  data   gl   pe   se   fl  des par stp dv fe lat
    vecs[0] = '{8,  1'b0, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 8, 0, 1, 1, 0, 79};
    vecs[1] = '{16, 1'b1, 8'h3C, 1'b0, 1'b1, 1'b0, 1'b0, 8, 1, 1, 0, 1, 171};
    vecs[2] = '{8,  1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 1, 7};
    vecs[3] = '{16, 1'b0, 8'h5A, 1'b0, 1'b0, 1'b1, 1'b0, 8, 0, 1, 0, 1, 155};
    vecs[4] = '{8,  1'b1, 8'h81, 1'b0, 1'b0, 1'b0, 1'b0, 8, 1, 1, 1, 0, 87};
    vecs[5] = '{8,  1'b0, 8'hC3, 1'b0, 1'b0, 1'b0, 1'b1, 8, 0, 1, 1, 0, 79};
    vecs[6] = '{8,  1'b0, 8'h0F, 1'b0, 1'b1, 1'b0, 1'b0, 8, 0, 1, 1, 0, 79};

    // Reset with the line held low: reset must win over start detection.
    RST = 1'b1; RX_IN = 1'b0; Sampled_Bit = 1'b0; PAR_EN = 1'b1; Prescale = PW'(8);
    par_err = 1'b0; stp_err = 1'b0; strt_glitch = 1'b0;
    repeat (3) @(negedge CLK);
    check("reset_samp_en", int'(data_samp_en), 0);
    check("reset_bit_count", int'(bit_count), 0);
    check("reset_strobes", int'({desrializer_en, strt_chk_en, par_chk_en, stp_chk_en}), 0);
    check("reset_flags", int'({DATA_VALID, frame_err}), 0);
    RX_IN = 1'b1;
    RST   = 1'b0;
    idle_cycles(3);
    check("idle_samp_en", int'(data_samp_en), 0);

    for (int i = 0; i < 7; i++) begin
      run_frame(vecs[i], 0, vecs[i].exp_lat + 3);
      verify_frame(vecs[i], 0, $sformatf("vec%0d", i));
      check($sformatf("vec%0d_end_samp_en", i), int'(data_samp_en), 0);
      check($sformatf("vec%0d_end_bit_count", i), int'(bit_count), 0);
      idle_cycles(4);
    end

    // Back-to-back: second start bit driven during the first frame's CHECK cycle.
    va = '{32, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8, 0, 1, 1, 0, 307};
    vb = '{32, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 8, 0, 1, 1, 0, 307};
    run_frame(va, 0, va.exp_lat + 1);
    verify_frame(va, 0, "b2b_first");
    run_frame(vb, 1, vb.exp_lat + 4);
    verify_frame(vb, 1, "b2b_second");
    idle_cycles(4);

    // Reset while receiving data bit 4.
    PAR_EN = 1'b0; Prescale = PW'(8); par_err = 1'b0; stp_err = 1'b0; strt_glitch = 1'b0;
    RX_IN = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 100 && !found; k++) begin
      @(posedge CLK);
      @(negedge CLK);
      RX_IN = 1'b1;
      if (bit_count == 4'd4) found = 1'b1;
    end
    check("rst_reach_bit4", int'(found), 1);
    RST = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    check("rst_mid_samp_en", int'(data_samp_en), 0);
    check("rst_mid_bit_count", int'(bit_count), 0);
    check("rst_mid_strobes", int'({desrializer_en, strt_chk_en, par_chk_en, stp_chk_en}), 0);
    check("rst_mid_flags", int'({DATA_VALID, frame_err}), 0);
    late = 0;
    for (int k = 0; k < 400; k++) begin
      @(negedge CLK);
      if (DATA_VALID || frame_err || desrializer_en || stp_chk_en || data_samp_en) late++;
    end
    check("rst_mid_no_followup", late, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
